object_matrix_server: RTL and testbench

- Responder side of the render pipeline's MVP-matrix read handshake (o_mvp_matrix_read_en / i_mvp_matrix / i_mvp_dv).
- Holds a per-frame object list: model id plus 4x4 MVP matrix per object.
- Top-level sequencer fills the list, commits it, then starts serving. The block answers the pipeline's read requests in order and flags the last object.
- Replaces single-matrix feeding from top_MH_FPGA so a frame can render up to MAX_OBJECTS objects.

---
 rtl/obj_server_pkg.sv | 52 +++++
 rtl/obj_entry_ram.sv | 42 ++++
 rtl/object_matrix_server.sv | 224 ++++++++++++++++++++++
 tb/tb_object_matrix_server.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obj_server_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : obj_server_pkg
//  Description : Shared types for the object matrix server. Holds the FSM
//                state encoding, the stored list entry layout and the helpers
//                that flatten and unflatten a 4x4 MVP matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
package obj_server_pkg;

  localparam int OBJ_DATAWIDTH      = 24;
  localparam int OBJ_MODEL_ID_WIDTH = 4;
  localparam int OBJ_MATRIX_BITS    = 16 * OBJ_DATAWIDTH;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    ARMED   = 3'd1,
    FETCH   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // One list entry as it sits in storage: model index on top, row-major
  // matrix below with element [r][c] at flat index r*4+c.
  typedef struct packed {
    logic [OBJ_MODEL_ID_WIDTH-1:0] model_id;
    logic [OBJ_MATRIX_BITS-1:0]    matrix;
  } obj_entry_t;

  function automatic logic [OBJ_MATRIX_BITS-1:0] pack_matrix(
    input logic signed [OBJ_DATAWIDTH-1:0] m [4][4]
  );
    logic [OBJ_MATRIX_BITS-1:0] flat;
    flat = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        flat[(r*4+c)*OBJ_DATAWIDTH +: OBJ_DATAWIDTH] = m[r][c];
      end
    end
    return flat;
  endfunction

  function automatic logic signed [OBJ_DATAWIDTH-1:0] unpack_elem(
    input logic [OBJ_MATRIX_BITS-1:0] flat,
    input int                         r,
    input int                         c
  );
    return flat[(r*4+c)*OBJ_DATAWIDTH +: OBJ_DATAWIDTH];
  endfunction

endpackage
`default_nettype wire

// File: rtl/obj_entry_ram.sv
`default_nettype none
// ============================================================================
//  Module      : obj_entry_ram
//  Description : Simple dual-port synchronous RAM for the object list. One
//                write port, one registered read port (1-cycle latency).
//                Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module obj_entry_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 388
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: store one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Read port: data appears the cycle after the read is issued.
  always_ff @(posedge clk) begin
    if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/object_matrix_server.sv
`default_nettype none
// ============================================================================
//  Module      : object_matrix_server
//  Description : Per-frame object list server. A sequencer fills the list
//                (model id + 4x4 MVP matrix per object), commits it and
//                starts serving; entries are then presented one at a time on
//                the pipeline's MVP read handshake, with the final entry
//                flagged.
//  Options     : OBJ_SERVER_REPLAY_EN - keep the list after serving so a new
//                start replays it; adds the list_clear input.
//  Revision    : 1.0 - initial release
// ============================================================================
module object_matrix_server
  import obj_server_pkg::*;
#(
  parameter int DATAWIDTH      = OBJ_DATAWIDTH,
  parameter int MODEL_ID_WIDTH = OBJ_MODEL_ID_WIDTH,
  parameter int MAX_OBJECTS    = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [MODEL_ID_WIDTH-1:0]      wr_model_id,
  input  logic signed [DATAWIDTH-1:0]    wr_matrix [4][4],
  input  logic                           wr_commit,
  output logic                           wr_ready,
  input  logic                           start,
`ifdef OBJ_SERVER_REPLAY_EN
  input  logic                           list_clear,
`endif
  input  logic                           mvp_read_en,
  output logic signed [DATAWIDTH-1:0]    o_mvp_matrix [4][4],
  output logic [MODEL_ID_WIDTH-1:0]      o_model_id,
  output logic                           o_mvp_dv,
  output logic                           o_obj_last,
  output logic                           finished,
  output logic                           overflow,
  output logic [$clog2(MAX_OBJECTS):0]   count
);

  localparam int             AW         = $clog2(MAX_OBJECTS);
  localparam int             CW         = AW + 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(MAX_OBJECTS);

  // The stored entry layout is fixed in the package; widths must agree.
  if (DATAWIDTH != OBJ_DATAWIDTH || MODEL_ID_WIDTH != OBJ_MODEL_ID_WIDTH ||
      MAX_OBJECTS < 2 || (MAX_OBJECTS & (MAX_OBJECTS - 1)) != 0) begin : g_bad_params
    $error("object_matrix_server: unsupported parameter combination");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          dv_q, dv_d;
  logic          last_q, last_d;
  logic          finished_q, finished_d;
  logic          overflow_q, overflow_d;
  obj_entry_t    entry_q, entry_d;

  obj_entry_t    w_wr_entry;
  obj_entry_t    w_rd_entry;
  logic          w_ram_we;
  logic          w_ram_re;
  logic          w_not_full;
  logic          w_list_clear;

`ifdef OBJ_SERVER_REPLAY_EN
  assign w_list_clear = list_clear;
`else
  assign w_list_clear = 1'b0;
`endif

  assign w_not_full = (count_q != FULL_COUNT);

  // Flatten the incoming matrix into the storage layout.
  always_comb begin
    w_wr_entry.model_id = wr_model_id;
    w_wr_entry.matrix   = pack_matrix(wr_matrix);
  end

  obj_entry_ram #(
    .DEPTH (MAX_OBJECTS),
    .WIDTH ($bits(obj_entry_t))
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (count_q[AW-1:0]),
    .i_wdata (w_wr_entry),
    .i_re    (w_ram_re),
    .i_raddr (ptr_q),
    .o_rdata (w_rd_entry)
  );

  // Next-state, list bookkeeping and output register updates.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    rd_pend_d  = rd_pend_q;
    dv_d       = dv_q;
    last_d     = last_q;
    finished_d = 1'b0;
    overflow_d = overflow_q;
    entry_d    = entry_q;
    w_ram_we   = 1'b0;
    w_ram_re   = 1'b0;

    case (state_q)
      FILL: begin
        // A write in the commit cycle still lands before arming.
        if (wr_en) begin
          if (w_not_full) begin
            w_ram_we = 1'b1;
            count_d  = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (wr_commit) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (w_list_clear) begin
          state_d = FILL;
          count_d = '0;
        end else if (start) begin
          ptr_d     = '0;
          rd_pend_d = 1'b0;
          if (count_q == '0) begin
            finished_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        // First cycle issues the read, second captures the RAM output.
        if (!rd_pend_q) begin
          w_ram_re  = 1'b1;
          rd_pend_d = 1'b1;
        end else begin
          entry_d   = w_rd_entry;
          dv_d      = 1'b1;
          last_d    = ({1'b0, ptr_q} == (count_q - CW'(1)));
          rd_pend_d = 1'b0;
          state_d   = PRESENT;
        end
      end

      PRESENT: begin
        if (mvp_read_en && dv_q) begin
          dv_d   = 1'b0;
          last_d = 1'b0;
          if (last_q) begin
            finished_d = 1'b1;
            state_d    = DONE;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = FETCH;
          end
        end
      end

      DONE: begin
`ifdef OBJ_SERVER_REPLAY_EN
        state_d = ARMED;
`else
        state_d = FILL;
        count_d = '0;
`endif
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and output registers; reset aborts any serve in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      count_q    <= '0;
      ptr_q      <= '0;
      rd_pend_q  <= 1'b0;
      dv_q       <= 1'b0;
      last_q     <= 1'b0;
      finished_q <= 1'b0;
      overflow_q <= 1'b0;
      entry_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      rd_pend_q  <= rd_pend_d;
      dv_q       <= dv_d;
      last_q     <= last_d;
      finished_q <= finished_d;
      overflow_q <= overflow_d;
      entry_q    <= entry_d;
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign o_mvp_matrix[r][c] = unpack_elem(entry_q.matrix, r, c);
    end
  end

  assign o_model_id = entry_q.model_id;
  assign o_mvp_dv   = dv_q;
  assign o_obj_last = last_q;
  assign finished   = finished_q;
  assign overflow   = overflow_q;
  assign count      = count_q;
  assign wr_ready   = (state_q == FILL) && w_not_full;

endmodule
`default_nettype wire

// File: tb/tb_object_matrix_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_object_matrix_server
//  Description : Self-checking bench for object_matrix_server (list of 4).
//                Expected entries are queued as they are written and popped
//                on every handshake transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_object_matrix_server;

  localparam int DW   = 24;
  localparam int IW   = 4;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO) + 1;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] m00;
    logic          last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_en = 1'b0;
  logic [IW-1:0]        wr_model_id = '0;
  logic signed [DW-1:0] wr_matrix [4][4];
  logic                 wr_commit = 1'b0;
  logic                 wr_ready;
  logic                 start = 1'b0;
`ifdef OBJ_SERVER_REPLAY_EN
  logic                 list_clear = 1'b0;
`endif
  logic                 mvp_read_en = 1'b0;
  logic signed [DW-1:0] o_mvp_matrix [4][4];
  logic [IW-1:0]        o_model_id;
  logic                 o_mvp_dv;
  logic                 o_obj_last;
  logic                 finished;
  logic                 overflow;
  logic [CW-1:0]        count;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   fin_cnt = 0;
  int   dv_cycles = 0;
  int   exp_count = 0;
  int   rises[$];
  logic dv_prev = 1'b0;
  exp_t sb[$];
  exp_t list_copy[$];
  exp_t mon_e;
  int   base;

  object_matrix_server #(
    .DATAWIDTH      (DW),
    .MODEL_ID_WIDTH (IW),
    .MAX_OBJECTS    (MAXO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_model_id  (wr_model_id),
    .wr_matrix    (wr_matrix),
    .wr_commit    (wr_commit),
    .wr_ready     (wr_ready),
    .start        (start),
`ifdef OBJ_SERVER_REPLAY_EN
    .list_clear   (list_clear),
`endif
    .mvp_read_en  (mvp_read_en),
    .o_mvp_matrix (o_mvp_matrix),
    .o_model_id   (o_model_id),
    .o_mvp_dv     (o_mvp_dv),
    .o_obj_last   (o_obj_last),
    .finished     (finished),
    .overflow     (overflow),
    .count        (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Element k (row-major) of an entry's matrix; some carry the sign bit.
  function automatic logic [DW-1:0] elem(input logic [DW-1:0] m00, input int k);
    if (k == 0) return m00;
    return m00 ^ (DW'(k) * 24'h05A5A3);
  endfunction

  // Handshake monitor and scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (finished) fin_cnt++;
      if (o_mvp_dv) dv_cycles++;
      if (o_mvp_dv && !dv_prev) rises.push_back(cyc);
      if (o_mvp_dv && mvp_read_en) begin
        check_eq("xfer_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("model_id", 64'(o_model_id), 64'(mon_e.id));
          check_eq("obj_last", 64'(o_obj_last), 64'(mon_e.last));
          for (int k = 0; k < 16; k++) begin
            check_eq("matrix_elem", 64'($unsigned(o_mvp_matrix[k/4][k%4])), 64'(elem(mon_e.m00, k)));
          end
        end
      end
    end
    dv_prev = o_mvp_dv;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] id, input logic [DW-1:0] m00);
    wr_model_id = id;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        wr_matrix[r][c] = elem(m00, r*4 + c);
    if (exp_count < MAXO) begin
      sb.push_back('{id, m00, 1'b0});
      exp_count++;
    end
  endtask

  task automatic write_entry(input logic [IW-1:0] id, input logic [DW-1:0] m00);
    load(id, m00);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic mark_committed();
    if (sb.size() != 0) sb[sb.size()-1].last = 1'b1;
    list_copy = sb;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    mark_committed();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_finished(input int target, input string tag);
    for (int i = 0; i < 200 && fin_cnt < target; i++) tick();
    check_eq(tag, 64'(fin_cnt >= target), 64'd1);
  endtask

  task automatic wait_dv(input string tag);
    for (int i = 0; i < 50 && !o_mvp_dv; i++) tick();
    check_eq(tag, 64'(o_mvp_dv), 64'd1);
  endtask

  // Return the block to an empty FILL state after a served list.
  task automatic after_list(input string tag);
`ifdef OBJ_SERVER_REPLAY_EN
    list_clear = 1'b1;
    tick();
    list_clear = 1'b0;
`endif
    exp_count = 0;
    check_eq({tag, "_ready"}, 64'(wr_ready), 64'd1);
    check_eq({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        wr_matrix[r][c] = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_wr_ready", 64'(wr_ready), 64'd1);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_dv", 64'(o_mvp_dv), 64'd0);
    check_eq("rst_last", 64'(o_obj_last), 64'd0);
    check_eq("rst_finished", 64'(finished), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_model_id", 64'(o_model_id), 64'd0);
    check_eq("rst_matrix", 64'($unsigned(o_mvp_matrix[0][0])), 64'd0);

    // Three entries, consumer always ready
    base = fin_cnt;
    rises.delete();
    write_entry(4'd1, 24'h002000);
    write_entry(4'd2, 24'h004000);
    write_entry(4'd3, 24'h006000);
    commit();
    check_eq("t1_count", 64'(count), 64'd3);
    check_eq("t1_armed_not_ready", 64'(wr_ready), 64'd0);
    pulse_start();
    mvp_read_en = 1'b1;
    wait_finished(base + 1, "t1_finished");
    repeat (4) tick();
    mvp_read_en = 1'b0;
    check_eq("t1_fin_once", 64'(fin_cnt - base), 64'd1);
    check_eq("t1_drained", 64'(sb.size()), 64'd0);
    check_eq("t1_dv_windows", 64'(rises.size()), 64'd3);
    if (rises.size() == 3) begin
      check_eq("t1_spacing_a", 64'(rises[1] - rises[0]), 64'd3);
      check_eq("t1_spacing_b", 64'(rises[2] - rises[1]), 64'd3);
    end
`ifdef OBJ_SERVER_REPLAY_EN
    // Replay the same list without refilling
    sb = list_copy;
    base = fin_cnt;
    pulse_start();
    mvp_read_en = 1'b1;
    wait_finished(base + 1, "t1r_finished");
    mvp_read_en = 1'b0;
    check_eq("t1r_drained", 64'(sb.size()), 64'd0);
`endif
    after_list("t1_back_to_fill");

    // Consumer stall
    write_entry(4'd4, 24'h00A000);
    write_entry(4'd5, 24'hF00000);
    commit();
    pulse_start();
    wait_dv("t2_dv1");
    for (int i = 0; i < 10; i++) begin
      check_eq("t2_hold", 64'({o_mvp_dv, o_model_id, $unsigned(o_mvp_matrix[0][0])}),
               64'({1'b1, 4'd4, 24'h00A000}));
      tick();
    end
    mvp_read_en = 1'b1;
    tick();
    mvp_read_en = 1'b0;
    repeat (5) tick();
    check_eq("t2_single_xfer", 64'({o_mvp_dv, o_model_id}), 64'({1'b1, 4'd5}));
    check_eq("t2_sb_left", 64'(sb.size()), 64'd1);
    base = fin_cnt;
    mvp_read_en = 1'b1;
    wait_finished(base + 1, "t2_finished");
    mvp_read_en = 1'b0;
    check_eq("t2_drained", 64'(sb.size()), 64'd0);
    after_list("t2_back_to_fill");

    // Capacity
    check_eq("t3_ovf_before", 64'(overflow), 64'd0);
    write_entry(4'd8, 24'h100001);
    write_entry(4'd9, 24'h200002);
    write_entry(4'd10, 24'h300003);
    write_entry(4'd11, 24'h400004);
    check_eq("t3_ready_full", 64'(wr_ready), 64'd0);
    check_eq("t3_count_full", 64'(count), 64'd4);
    write_entry(4'd12, 24'h500005);
    check_eq("t3_overflow", 64'(overflow), 64'd1);
    check_eq("t3_count_kept", 64'(count), 64'd4);
    commit();
    base = fin_cnt;
    pulse_start();
    mvp_read_en = 1'b1;
    wait_finished(base + 1, "t3_finished");
    mvp_read_en = 1'b0;
    check_eq("t3_drained", 64'(sb.size()), 64'd0);
    after_list("t3_back_to_fill");

    // Empty list
    base = fin_cnt;
    dv_cycles = 0;
    commit();
    pulse_start();
    mvp_read_en = 1'b1;
    wait_finished(base + 1, "t4_finished");
    repeat (3) tick();
    mvp_read_en = 1'b0;
    check_eq("t4_fin_once", 64'(fin_cnt - base), 64'd1);
    check_eq("t4_no_dv", 64'(dv_cycles), 64'd0);
    check_eq("t4_ovf_sticky", 64'(overflow), 64'd1);
    after_list("t4_back_to_fill");

    // Same-cycle write and commit
    load(4'd7, 24'h7FF001);
    wr_en = 1'b1;
    wr_commit = 1'b1;
    tick();
    wr_en = 1'b0;
    wr_commit = 1'b0;
    mark_committed();
    check_eq("t5_count", 64'(count), 64'd1);
    check_eq("t5_armed", 64'(wr_ready), 64'd0);
    base = fin_cnt;
    pulse_start();
    mvp_read_en = 1'b1;
    wait_finished(base + 1, "t5_finished");
    mvp_read_en = 1'b0;
    check_eq("t5_drained", 64'(sb.size()), 64'd0);
    after_list("t5_back_to_fill");

    // Reset during presentation of entry 2 of 3
    write_entry(4'd1, 24'h002000);
    write_entry(4'd2, 24'h004000);
    write_entry(4'd3, 24'h006000);
    commit();
    pulse_start();
    wait_dv("t6_dv1");
    mvp_read_en = 1'b1;
    tick();
    mvp_read_en = 1'b0;
    wait_dv("t6_dv2");
    check_eq("t6_entry2", 64'(o_model_id), 64'd2);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_dv", 64'(o_mvp_dv), 64'd0);
    check_eq("t6_async_count", 64'(count), 64'd0);
    sb.delete();
    exp_count = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("t6_ready_after", 64'(wr_ready), 64'd1);
    check_eq("t6_ovf_cleared", 64'(overflow), 64'd0);
    check_eq("t6_dv_after", 64'(o_mvp_dv), 64'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
